// File: rtl/hazard_scoreboard.sv
// Decode-stage register/CSR hazard scoreboard with per-register pending-write counters.
// Latency: stall_o is combinational from registered counters; counter updates land at the next edge.
// Backpressure: stall_o blocks hand-off on RAW, CSR-serialisation or counter saturation; no bypass.
module hazard_scoreboard #(
  parameter int CNT_W = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        valid_i,
  input  logic        fire_i,
  input  logic        rena1_i,
  input  logic [4:0]  raddr1_i,
  input  logic        rena2_i,
  input  logic [4:0]  raddr2_i,
  input  logic        wena_i,
  input  logic [4:0]  waddr_i,
  input  logic        csr_rena_i,
  input  logic        csr_wena_i,
  input  logic        wb_wena_i,
  input  logic [4:0]  wb_waddr_i,
  input  logic        wb_csr_wena_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic [31:0] busy_o,
  output logic        csr_busy_o,
  output logic        pending_o,
  output logic        err_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Entry 0 exists only so indexing by a 5-bit address is total; it is held at zero.
  logic [31:0][CNT_W-1:0] cnt;
  logic [31:0][CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0]       csr_cnt;
  logic [CNT_W-1:0]       csr_nxt;
  logic [31:0]            inc_vec;
  logic [31:0]            dec_vec;
  logic                   haz1;
  logic                   haz2;
  logic                   hazc;
  logic                   sat;
  logic                   issue;
  logic                   csr_inc;
  logic                   csr_dec;
  logic                   err_set;

  // Hazard detection against registered counters only, so a same-cycle write-back never bypasses.
  always_comb begin
    haz1    = rena1_i && (raddr1_i != 5'd0) && (cnt[raddr1_i] != '0);
    haz2    = rena2_i && (raddr2_i != 5'd0) && (cnt[raddr2_i] != '0);
    hazc    = (csr_rena_i || csr_wena_i) && (csr_cnt != '0);
    sat     = (wena_i && (waddr_i != 5'd0) && (cnt[waddr_i] == CNT_MAX)) ||
              (csr_wena_i && (csr_cnt == CNT_MAX));
    stall_o = valid_i && (haz1 || haz2 || hazc || sat);
  end

  // One-hot issue/write-back decode; x0 is never tracked.
  always_comb begin
    issue   = fire_i & valid_i & ~stall_o;
    inc_vec = '0;
    dec_vec = '0;
    if (issue && wena_i) inc_vec[waddr_i] = 1'b1;
    if (wb_wena_i)       dec_vec[wb_waddr_i] = 1'b1;
    inc_vec[0] = 1'b0;
    dec_vec[0] = 1'b0;
    csr_inc = issue & csr_wena_i;
    csr_dec = wb_csr_wena_i;
  end

  // Next counter values: issue+write-back cancel, write-back at zero is clamped and flagged, flush wins.
  always_comb begin
    cnt_nxt = cnt;
    csr_nxt = csr_cnt;
    err_set = fire_i & (~valid_i | stall_o);
    cnt_nxt[0] = '0;
    for (int r = 1; r < 32; r++) begin
      if (dec_vec[r] && (cnt[r] == '0)) err_set = 1'b1;
      if (inc_vec[r] && !dec_vec[r]) begin
        cnt_nxt[r] = cnt[r] + CNT_ONE;
      end else if (dec_vec[r] && !inc_vec[r] && (cnt[r] != '0)) begin
        cnt_nxt[r] = cnt[r] - CNT_ONE;
      end
    end
    if (csr_dec && (csr_cnt == '0)) err_set = 1'b1;
    if (csr_inc && !csr_dec) begin
      csr_nxt = csr_cnt + CNT_ONE;
    end else if (csr_dec && !csr_inc && (csr_cnt != '0)) begin
      csr_nxt = csr_cnt - CNT_ONE;
    end
    if (flush_i) begin
      cnt_nxt = '0;
      csr_nxt = '0;
    end
  end

  // Counter and sticky error state; only reset clears the error flag.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      csr_cnt <= '0;
      err_o   <= 1'b0;
    end else begin
      cnt     <= cnt_nxt;
      csr_cnt <= csr_nxt;
      err_o   <= err_o | err_set;
    end
  end

  // Status outputs decoded purely from registered counters.
  always_comb begin
    busy_o[0] = 1'b0;
    for (int r = 1; r < 32; r++) begin
      busy_o[r] = |cnt[r];
    end
    csr_busy_o = |csr_cnt;
    pending_o  = (|busy_o) | csr_busy_o;
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed scenarios plus randomized traffic against an integer model.
// Latency: model state advances once per cycle alongside the DUT.
// Backpressure: stimulus mostly respects stall_o, occasionally violates it to exercise the error flag.
module tb_hazard_scoreboard;

  localparam int CNT_W = 2;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic        clock;
  logic        reset;
  logic        valid_i, fire_i;
  logic        rena1_i, rena2_i, wena_i;
  logic [4:0]  raddr1_i, raddr2_i, waddr_i;
  logic        csr_rena_i, csr_wena_i;
  logic        wb_wena_i;
  logic [4:0]  wb_waddr_i;
  logic        wb_csr_wena_i;
  logic        flush_i;
  logic        stall_o;
  logic [31:0] busy_o;
  logic        csr_busy_o, pending_o, err_o;

  int n_tests;
  int n_fail;

  // Behavioural model: plain integer pending counts per register.
  int mcnt [32];
  int mcsr;
  bit merr;

  hazard_scoreboard #(.CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .valid_i(valid_i), .fire_i(fire_i),
    .rena1_i(rena1_i), .raddr1_i(raddr1_i), .rena2_i(rena2_i), .raddr2_i(raddr2_i),
    .wena_i(wena_i), .waddr_i(waddr_i), .csr_rena_i(csr_rena_i), .csr_wena_i(csr_wena_i),
    .wb_wena_i(wb_wena_i), .wb_waddr_i(wb_waddr_i), .wb_csr_wena_i(wb_csr_wena_i),
    .flush_i(flush_i), .stall_o(stall_o), .busy_o(busy_o), .csr_busy_o(csr_busy_o),
    .pending_o(pending_o), .err_o(err_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_stall();
    bit h1, h2, hc, st;
    if (!valid_i) return 1'b0;
    h1 = rena1_i && raddr1_i != 0 && mcnt[raddr1_i] > 0;
    h2 = rena2_i && raddr2_i != 0 && mcnt[raddr2_i] > 0;
    hc = (csr_rena_i || csr_wena_i) && mcsr > 0;
    st = (wena_i && waddr_i != 0 && mcnt[waddr_i] == MAXC) || (csr_wena_i && mcsr == MAXC);
    return h1 || h2 || hc || st;
  endfunction

  task automatic model_clear(input bit clr_err);
    for (int i = 0; i < 32; i++) mcnt[i] = 0;
    mcsr = 0;
    if (clr_err) merr = 1'b0;
  endtask

  task automatic compare_all();
    logic [31:0] eb;
    eb = '0;
    for (int i = 1; i < 32; i++) if (mcnt[i] > 0) eb[i] = 1'b1;
    chk("stall", {31'd0, stall_o}, {31'd0, m_stall()});
    chk("busy", busy_o, eb);
    chk("csr_busy", {31'd0, csr_busy_o}, {31'd0, mcsr > 0});
    chk("pending", {31'd0, pending_o}, {31'd0, (eb != 0) || mcsr > 0});
    chk("err", {31'd0, err_o}, {31'd0, merr});
  endtask

  // One clock: compare at the falling edge, then advance the model with the inputs seen at the edge.
  task automatic cyc();
    int  nc [32];
    int  ncsr;
    bit  nerr, st, issue;
    @(negedge clock);
    compare_all();
    for (int i = 0; i < 32; i++) nc[i] = mcnt[i];
    ncsr = mcsr;
    nerr = merr;
    st = m_stall();
    issue = fire_i && valid_i && !st;
    if (fire_i && !issue) nerr = 1'b1;
    if (wb_wena_i && wb_waddr_i != 0 && mcnt[wb_waddr_i] == 0) nerr = 1'b1;
    if (wb_csr_wena_i && mcsr == 0) nerr = 1'b1;
    if (issue && wena_i && waddr_i != 0) nc[waddr_i] += 1;
    if (issue && csr_wena_i) ncsr += 1;
    if (wb_wena_i && wb_waddr_i != 0 && nc[wb_waddr_i] > 0) nc[wb_waddr_i] -= 1;
    if (wb_csr_wena_i && ncsr > 0) ncsr -= 1;
    if (flush_i) begin
      for (int i = 0; i < 32; i++) nc[i] = 0;
      ncsr = 0;
    end
    @(posedge clock);
    if (reset) begin
      for (int i = 0; i < 32; i++) mcnt[i] = nc[i];
      mcsr = ncsr;
      merr = nerr;
    end else begin
      model_clear(1'b1);
    end
    #1;
  endtask

  task automatic clr();
    valid_i = 0; fire_i = 0; rena1_i = 0; raddr1_i = 0; rena2_i = 0; raddr2_i = 0;
    wena_i = 0; waddr_i = 0; csr_rena_i = 0; csr_wena_i = 0;
    wb_wena_i = 0; wb_waddr_i = 0; wb_csr_wena_i = 0; flush_i = 0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_clear(1'b1);
  endtask

  task automatic issue_w(input logic [4:0] a);
    clr(); valid_i = 1; fire_i = 1; wena_i = 1; waddr_i = a;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    clr();
    do_reset();
    // Reset state, with a hazardous-looking instruction presented.
    valid_i = 1; rena1_i = 1; raddr1_i = 5; wena_i = 1; waddr_i = 5;
    repeat (2) cyc();
    chk("rst_busy", busy_o, 32'h0);
    chk("rst_err", {31'd0, err_o}, 32'd0);
    chk("rst_stall", {31'd0, stall_o}, 32'd0);
    reset = 1'b1;
    clr();
    cyc();

    // RAW on x5, no bypass from write-back.
    issue_w(5); cyc();
    clr(); #1 chk("x5_busy", busy_o, 32'h20);
    valid_i = 1; rena1_i = 1; raddr1_i = 5; #1 chk("x5_raw", {31'd0, stall_o}, 32'd1);
    wb_wena_i = 1; wb_waddr_i = 5; #1 chk("x5_nobypass", {31'd0, stall_o}, 32'd1);
    cyc();
    wb_wena_i = 0; #1 chk("x5_release", {31'd0, stall_o}, 32'd0);

    // Saturation on x7.
    repeat (3) begin issue_w(7); cyc(); end
    clr(); valid_i = 1; wena_i = 1; waddr_i = 7; #1 chk("x7_sat", {31'd0, stall_o}, 32'd1);
    wb_wena_i = 1; wb_waddr_i = 7; cyc();
    wb_wena_i = 0; #1 chk("x7_unsat", {31'd0, stall_o}, 32'd0);
    clr(); wb_wena_i = 1; wb_waddr_i = 7; cyc(); cyc();
    clr(); #1 chk("x7_drain", busy_o, 32'h0);

    // Simultaneous issue and write-back on x9.
    issue_w(9); cyc();
    wb_wena_i = 1; wb_waddr_i = 9; cyc();
    clr(); #1 chk("x9_same", busy_o, 32'h200);
    wb_wena_i = 1; wb_waddr_i = 9; cyc();
    clr(); #1 chk("x9_drain", busy_o, 32'h0);

    // x0 is never tracked.
    issue_w(0); rena1_i = 1; raddr1_i = 0; #1 chk("x0_stall", {31'd0, stall_o}, 32'd0);
    cyc();
    clr(); #1 chk("x0_busy", busy_o, 32'h0);
    wb_wena_i = 1; wb_waddr_i = 0; cyc();
    clr(); #1 chk("x0_wb_err", {31'd0, err_o}, 32'd0);

    // CSR serialisation and flush priority.
    clr(); valid_i = 1; fire_i = 1; csr_wena_i = 1; cyc();
    clr(); valid_i = 1; csr_rena_i = 1; #1 chk("csr_stall", {31'd0, stall_o}, 32'd1);
    chk("csr_busy1", {31'd0, csr_busy_o}, 32'd1);
    cyc();
    issue_w(3); flush_i = 1; cyc();
    clr(); #1 chk("flush_pending", {31'd0, pending_o}, 32'd0);
    chk("flush_busy", busy_o, 32'h0);

    // Sticky error, stalled fire ignored, reset clears the error.
    wb_wena_i = 1; wb_waddr_i = 12; cyc();
    clr(); #1 chk("err_set", {31'd0, err_o}, 32'd1);
    flush_i = 1; cyc();
    clr(); #1 chk("err_flush", {31'd0, err_o}, 32'd1);
    issue_w(4); cyc();
    clr(); valid_i = 1; fire_i = 1; rena1_i = 1; raddr1_i = 4; wena_i = 1; waddr_i = 4;
    #1 chk("x4_stall", {31'd0, stall_o}, 32'd1);
    cyc();
    clr(); wb_wena_i = 1; wb_waddr_i = 4; cyc();
    clr(); #1 chk("x4_ignored", busy_o, 32'h0);
    do_reset(); #1 chk("err_rst", {31'd0, err_o}, 32'd0);
    cyc();
    reset = 1'b1;

    // Mid-operation reset discards pending state; late write-back is then an error.
    issue_w(6); cyc();
    clr(); do_reset(); #1 chk("rst_mid_busy", busy_o, 32'h0);
    cyc();
    reset = 1'b1;
    wb_wena_i = 1; wb_waddr_i = 6; cyc();
    clr(); #1 chk("late_wb_err", {31'd0, err_o}, 32'd1);
    do_reset(); cyc(); reset = 1'b1;

    // Randomized traffic against the model.
    for (int n = 0; n < 2000; n++) begin
      int a;
      clr();
      if (n % 400 == 399) begin
        do_reset();
        cyc();
        reset = 1'b1;
        continue;
      end
      valid_i    = ($urandom % 4) != 0;
      rena1_i    = $urandom % 2; raddr1_i = 5'($urandom_range(0, 7));
      rena2_i    = $urandom % 2; raddr2_i = 5'($urandom_range(0, 7));
      wena_i     = $urandom % 2; waddr_i  = 5'($urandom_range(0, 7));
      csr_rena_i = ($urandom % 8) == 0;
      csr_wena_i = ($urandom % 8) == 0;
      fire_i     = (valid_i && ($urandom % 4) != 0 && (!m_stall() || ($urandom % 32) == 0)) ||
                   (!valid_i && ($urandom % 64) == 0);
      a = $urandom_range(0, 7);
      wb_waddr_i    = 5'(a);
      wb_wena_i     = (mcnt[a] > 0) ? ($urandom % 2) : (($urandom % 40) == 0);
      wb_csr_wena_i = (mcsr > 0) ? (($urandom % 3) == 0) : (($urandom % 60) == 0);
      flush_i       = ($urandom % 50) == 0;
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
